// File: rtl/seg7_pkg.sv
// Shared types for the seven-segment glyph streamer: segment flags and FSM states.
package seg7_pkg;

  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_flags_t;

  typedef union packed {
    seg_flags_t seg;
    logic [7:0] raw;
  } segments_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/seg7_column_render.sv
// Combinational renderer: one 8-pixel page column of a seven-segment glyph.
// Build option: define SEG7_DP_EN to draw the decimal point in the trailing columns.
module seg7_column_render
  import seg7_pkg::*;
#(
  parameter int GLYPH_W = 21,
  parameter int PAGES   = 4,
  parameter int SPACE   = 2,
  parameter int THICK   = 4,
  localparam int CW     = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  segments_t         seg_i,
  input  logic     [CW-1:0] col_i,
  input  logic     [PW-1:0] page_i,
  output logic     [7:0]    col_o
);

  localparam int H      = 8 * PAGES;
  localparam int BODY_W = GLYPH_W - SPACE - 3;
  localparam int MID_LO = H / 2 - THICK / 2;
  localparam int MID_HI = H / 2 + THICK / 2;

  int   x;
  int   row;
  logic horiz;
  logic left;
  logic right;
  logic lit;

  // NOTE: every variable gets a value before any conditional path, so no latch is inferred.
  always_comb begin
    col_o = '0;
    row   = 0;
    lit   = 1'b0;
    x     = int'(col_i) - SPACE;
    horiz = (x >= THICK) && (x < BODY_W - THICK);
    left  = (x >= 0) && (x < THICK);
    right = (x >= BODY_W - THICK) && (x < BODY_W);
    for (int k = 0; k < 8; k++) begin
      row = int'(page_i) * 8 + k;
      lit = 1'b0;
      if (seg_i.seg.a && horiz && row < THICK)                      lit = 1'b1;
      if (seg_i.seg.g && horiz && row >= MID_LO && row < MID_HI)    lit = 1'b1;
      if (seg_i.seg.d && horiz && row >= H - THICK && row < H)      lit = 1'b1;
      if (seg_i.seg.f && left  && row >= THICK && row < MID_LO)     lit = 1'b1;
      if (seg_i.seg.e && left  && row >= MID_HI && row < H - THICK) lit = 1'b1;
      if (seg_i.seg.b && right && row >= THICK && row < MID_LO)     lit = 1'b1;
      if (seg_i.seg.c && right && row >= MID_HI && row < H - THICK) lit = 1'b1;
`ifdef SEG7_DP_EN
      // Decimal point: square in the last two columns, bottom THICK rows.
      if (seg_i.seg.dp && int'(col_i) >= GLYPH_W - 2 && row >= H - THICK) lit = 1'b1;
`endif
      col_o[k] = lit;
    end
  end

`ifndef SEG7_DP_EN
  logic unused_dp;
  assign unused_dp = seg_i.seg.dp;
`endif

endmodule

// File: rtl/seg7_glyph_streamer.sv
// Streams a row of seven-segment glyphs as SSD1306 page-format bytes (page, digit, column order).
// Build option: SEG7_DP_EN enables decimal-point rendering in seg7_column_render.
module seg7_glyph_streamer
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 6,
  parameter int GLYPH_W = 21,
  parameter int PAGES   = 4,
  parameter int SPACE   = 2,
  parameter int THICK   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  segments_t [DIGITS-1:0] segments_in,
  output logic      [7:0]        col_data,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic                   col_last,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;

  state_e                 state_q, state_d;
  logic      [PW-1:0]     pg_q, pg_d, pg_nx, fetch_pg;
  logic      [DW-1:0]     dig_q, dig_d, dig_nx, fetch_dig;
  logic      [CW-1:0]     col_q, col_d, col_nx, fetch_col;
  logic      [7:0]        data_q, data_d, render_col;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fetch_last;
  logic                   snap_load;
  segments_t [DIGITS-1:0] snap_q;

  // Counter successor in column -> digit -> page order.
  always_comb begin
    col_nx = col_q + CW'(1);
    dig_nx = dig_q;
    pg_nx  = pg_q;
    if (col_q == CW'(GLYPH_W - 1)) begin
      col_nx = '0;
      dig_nx = dig_q + DW'(1);
      if (dig_q == DW'(DIGITS - 1)) begin
        dig_nx = '0;
        pg_nx  = pg_q + PW'(1);
      end
    end
  end

  // The first byte renders the cleared counters; later bytes render their successor.
  assign fetch_pg   = valid_q ? pg_nx  : pg_q;
  assign fetch_dig  = valid_q ? dig_nx : dig_q;
  assign fetch_col  = valid_q ? col_nx : col_q;
  assign fetch_last = (fetch_pg == PW'(PAGES - 1)) && (fetch_dig == DW'(DIGITS - 1)) &&
                      (fetch_col == CW'(GLYPH_W - 1));

  seg7_column_render #(
    .GLYPH_W (GLYPH_W),
    .PAGES   (PAGES),
    .SPACE   (SPACE),
    .THICK   (THICK)
  ) u_render (
    .seg_i  (snap_q[fetch_dig]),
    .col_i  (fetch_col),
    .page_i (fetch_pg),
    .col_o  (render_col)
  );

  always_comb begin
    state_d   = state_q;
    pg_d      = pg_q;
    dig_d     = dig_q;
    col_d     = col_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          pg_d      = '0;
          dig_d     = '0;
          col_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!valid_q) begin
          data_d  = render_col;
          last_d  = fetch_last;
          valid_d = 1'b1;
        end else if (col_ready) begin
          if (last_q) begin
            data_d  = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            pg_d   = pg_nx;
            dig_d  = dig_nx;
            col_d  = col_nx;
            data_d = render_col;
            last_d = fetch_last;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pg_q    <= '0;
      dig_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pg_q    <= pg_d;
      dig_q   <= dig_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the snapshot is storage, not control; it is always written on start before it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (snap_load) snap_q <= segments_in;
  end

  assign col_data  = data_q;
  assign col_valid = valid_q;
  assign col_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg7_glyph_streamer.sv
// Randomized self-checking bench for seg7_glyph_streamer against a frame-buffer reference model.
module tb_seg7_glyph_streamer;
  import seg7_pkg::*;

  localparam int DIGITS  = 6;
  localparam int GLYPH_W = 21;
  localparam int PAGES   = 4;
  localparam int SPACE   = 2;
  localparam int THICK   = 4;
  localparam int H       = 8 * PAGES;
  localparam int BODY_W  = GLYPH_W - SPACE - 3;
  localparam int ROW_W   = DIGITS * GLYPH_W;
  localparam int TOTAL   = ROW_W * PAGES;
  localparam int BUDGET  = 8 * TOTAL;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  segments_t [DIGITS-1:0] segments_in;
  logic      [7:0]        col_data;
  logic                   col_valid;
  logic                   col_ready;
  logic                   col_last;
  logic                   busy;
  logic                   done;

  int        n_vec = 0;
  int        n_err = 0;
  logic [7:0] exp_b [TOTAL];
  logic [7:0] got_b [TOTAL];
  logic       pix   [ROW_W][H];

  always #5 clk = ~clk;

  seg7_glyph_streamer #(
    .DIGITS  (DIGITS),
    .GLYPH_W (GLYPH_W),
    .PAGES   (PAGES),
    .SPACE   (SPACE),
    .THICK   (THICK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .segments_in (segments_in),
    .col_data    (col_data),
    .col_valid   (col_valid),
    .col_ready   (col_ready),
    .col_last    (col_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: paint each enabled segment rectangle into a pixel frame, then slice into page bytes.
  task automatic paint(input int d, input int x0, input int x1, input int r0, input int r1);
    for (int x = x0; x < x1; x++)
      for (int r = r0; r < r1; r++)
        pix[d * GLYPH_W + x][r] = 1'b1;
  endtask

  task automatic build_model(input segments_t [DIGITS-1:0] segs);
    int bx;
    int idx;
    bx = SPACE;
    for (int c = 0; c < ROW_W; c++)
      for (int r = 0; r < H; r++)
        pix[c][r] = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (segs[d].seg.a) paint(d, bx + THICK, bx + BODY_W - THICK, 0, THICK);
      if (segs[d].seg.g) paint(d, bx + THICK, bx + BODY_W - THICK, H/2 - THICK/2, H/2 + THICK/2);
      if (segs[d].seg.d) paint(d, bx + THICK, bx + BODY_W - THICK, H - THICK, H);
      if (segs[d].seg.f) paint(d, bx, bx + THICK, THICK, H/2 - THICK/2);
      if (segs[d].seg.e) paint(d, bx, bx + THICK, H/2 + THICK/2, H - THICK);
      if (segs[d].seg.b) paint(d, bx + BODY_W - THICK, bx + BODY_W, THICK, H/2 - THICK/2);
      if (segs[d].seg.c) paint(d, bx + BODY_W - THICK, bx + BODY_W, H/2 + THICK/2, H - THICK);
`ifdef SEG7_DP_EN
      if (segs[d].seg.dp) paint(d, GLYPH_W - 2, GLYPH_W, H - THICK, H);
`endif
    end
    idx = 0;
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < ROW_W; c++) begin
        for (int k = 0; k < 8; k++) exp_b[idx][k] = pix[c][p * 8 + k];
        idx++;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame. rand_ready toggles col_ready; disturb changes inputs and pulses start mid-frame;
  // abort_at >= 0 asserts reset just before that byte is accepted.
  task automatic run_frame(input segments_t [DIGITS-1:0] segs, input bit rand_ready,
                           input bit disturb, input int abort_at);
    int   idx;
    int   cyc;
    bit   stalled;
    logic [7:0] held_data;
    logic held_last;
    build_model(segs);
    segments_in = segs;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_valid", 32'(col_valid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (idx < TOTAL && cyc < BUDGET) begin
      if (stalled) begin
        check("stall_valid", 32'(col_valid), 32'd1);
        check("stall_data", 32'(col_data), 32'(held_data));
        check("stall_last", 32'(col_last), 32'(held_last));
      end
      start = 1'b0;
      if (disturb && idx == 50) begin
        for (int d = 0; d < DIGITS; d++) segments_in[d].raw = 8'($urandom);
        start = 1'b1;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        col_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_valid", 32'(col_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_last", 32'(col_last), 32'd0);
        check("abort_data", 32'(col_data), 32'd0);
        tick();
        check("abort_idle", 32'(col_valid), 32'd0);
        return;
      end
      col_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (col_valid && col_ready) begin
        got_b[idx] = col_data;
        check($sformatf("byte%0d", idx), 32'(col_data), 32'(exp_b[idx]));
        check($sformatf("last%0d", idx), 32'(col_last), 32'(idx == TOTAL - 1));
        idx++;
      end
      stalled = col_valid && !col_ready;
      held_data = col_data;
      held_last = col_last;
      tick();
      cyc++;
    end
    start = 1'b0;
    col_ready = 1'b0;
    check("frame_bytes", 32'(idx), 32'(TOTAL));
    check("end_valid", 32'(col_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    if (disturb) begin
      tick();
      tick();
      check("no_refire_valid", 32'(col_valid), 32'd0);
      check("no_refire_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    segments_t [DIGITS-1:0] segs;
    reset_n = 1'b0;
    start = 1'b0;
    col_ready = 1'b0;
    segments_in = '0;
    tick();
    tick();
    check("rst_data", 32'(col_data), 32'd0);
    check("rst_valid", 32'(col_valid), 32'd0);
    check("rst_last", 32'(col_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Digit "8" in position 0, sink always ready.
    segs = '0;
    segs[0].raw = 8'h7F;
    run_frame(segs, 1'b0, 1'b0, -1);
    check("d8_c2_p0", 32'(got_b[0 * ROW_W + 2]), 32'h00F0);
    check("d8_c2_p1", 32'(got_b[1 * ROW_W + 2]), 32'h003F);
    check("d8_c2_p2", 32'(got_b[2 * ROW_W + 2]), 32'h00FC);
    check("d8_c2_p3", 32'(got_b[3 * ROW_W + 2]), 32'h000F);
    check("d8_c6_p0", 32'(got_b[0 * ROW_W + 6]), 32'h000F);
    check("d8_c6_p1", 32'(got_b[1 * ROW_W + 6]), 32'h00C0);
    check("d8_c6_p2", 32'(got_b[2 * ROW_W + 6]), 32'h0003);
    check("d8_c6_p3", 32'(got_b[3 * ROW_W + 6]), 32'h00F0);

    // Same frame with a stalling sink.
    run_frame(segs, 1'b1, 1'b0, -1);

    // Blank frame.
    run_frame('0, 1'b0, 1'b0, -1);
    for (int i = 0; i < TOTAL; i += 37) check("blank", 32'(got_b[i]), 32'd0);

    // Decimal point on digit 2.
    segs = '0;
    segs[2].raw = 8'h80;
    run_frame(segs, 1'b1, 1'b0, -1);
`ifdef SEG7_DP_EN
    check("dp_c19", 32'(got_b[3 * ROW_W + 2 * GLYPH_W + 19]), 32'h00F0);
    check("dp_c20", 32'(got_b[3 * ROW_W + 2 * GLYPH_W + 20]), 32'h00F0);
`else
    check("dp_c19", 32'(got_b[3 * ROW_W + 2 * GLYPH_W + 19]), 32'h0000);
    check("dp_c20", 32'(got_b[3 * ROW_W + 2 * GLYPH_W + 20]), 32'h0000);
`endif

    // Inputs disturbed and start pulsed mid-frame.
    for (int d = 0; d < DIGITS; d++) segs[d].raw = 8'($urandom);
    run_frame(segs, 1'b1, 1'b1, -1);

    // Reset at byte 100, then a fresh full frame.
    for (int d = 0; d < DIGITS; d++) segs[d].raw = 8'($urandom);
    run_frame(segs, 1'b1, 1'b0, 100);
    run_frame(segs, 1'b0, 1'b0, -1);

    // Random frames.
    for (int n = 0; n < 4; n++) begin
      for (int d = 0; d < DIGITS; d++) segs[d].raw = 8'($urandom);
      run_frame(segs, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
